// File: rtl/mult_datapath.sv
// mult_datapath -- register/arithmetic datapath of the signed add-shift multiplier.
//
// Holds the X:A:B shift chain and a WIDTH+1 bit adder/subtractor driven by
// the multiplier controller's strobes. After a completed multiply the signed
// product is {Aval, Bval} and X carries its sign.
//
// Ports:
//   Clk        system clock, all state updates on the rising edge
//   Reset      synchronous active-high reset, overrides every strobe
//   S          switch operand: multiplier on Clr_ld, multiplicand on Add/Sub
//   Clr_ld     clear A and X, load B from S, clear the shift counter
//   Shift      arithmetic right shift of X:A:B
//   Add, Sub   A <= A +/- S (signed); Sub wins if both are high
//   Aval, Bval A and B registers (product upper / lower half)
//   X          sign-extension flip-flop
//   M          B[0], fed back to the controller
//   Shift_cnt  shifts since the last Clr_ld, saturating at WIDTH
//   Done       Shift_cnt == WIDTH
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [WIDTH-1:0]             S,
    input  logic                         Clr_ld,
    input  logic                         Shift,
    input  logic                         Add,
    input  logic                         Sub,
    output logic [WIDTH-1:0]             Aval,
    output logic [WIDTH-1:0]             Bval,
    output logic                         X,
    output logic                         M,
    output logic [$clog2(WIDTH+1)-1:0]   Shift_cnt,
    output logic                         Done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] a_q, b_q;
    logic             x_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   op;
    logic [WIDTH:0]   sum;
    logic [CW-1:0]    cnt_inc;

    // Operand is S sign-extended to WIDTH+1 bits, negated for Sub.
    // The adder carry out of the top bit is simply dropped.
    always_comb begin
        op = {S[WIDTH-1], S};
        if (Sub)
            op = ~{S[WIDTH-1], S} + 1'b1;
        sum = {a_q[WIDTH-1], a_q} + op;
    end

    // Counter sticks at WIDTH; the chain itself keeps shifting past that.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else if (Clr_ld) begin
            a_q   <= '0;
            b_q   <= S;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else if (Add || Sub) begin
            x_q <= sum[WIDTH];
            if (Shift) begin
                // Final-subtract state: shift the freshly computed sum in
                // the same cycle, with the new X as the incoming sign bit.
                a_q   <= {sum[WIDTH], sum[WIDTH-1:1]};
                b_q   <= {sum[0], b_q[WIDTH-1:1]};
                cnt_q <= cnt_inc;
            end else begin
                a_q <= sum[WIDTH-1:0];
            end
        end else if (Shift) begin
            a_q   <= {x_q, a_q[WIDTH-1:1]};
            b_q   <= {a_q[0], b_q[WIDTH-1:1]};
            cnt_q <= cnt_inc;
        end
    end

    assign Aval      = a_q;
    assign Bval      = b_q;
    assign X         = x_q;
    assign M         = b_q[0];
    assign Shift_cnt = cnt_q;
    assign Done      = (cnt_q == CNT_MAX);

endmodule
